// File: rtl/ht_pkg.sv
// Shared constants, FSM encoding and node record for the Huffman code builder.
// Keys {weight, order} are unique, so min selection never has to break a tie.
package ht_pkg;

  localparam int N_CHAR   = 8;
  localparam int WEIGHT_W = 5;
  localparam int NODE_W   = 8;
  localparam int ORDER_W  = 4;
  localparam int CODE_W   = 7;
  localparam int IDX_W    = 3;
  localparam int KEY_W    = NODE_W + ORDER_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MERGE,
    S_OUT
  } state_t;

  typedef struct packed {
    logic [NODE_W-1:0]  weight;
    logic [ORDER_W-1:0] order;
    logic               active;
    logic [N_CHAR-1:0]  mask;
  } node_t;

  function automatic node_t make_leaf(input logic [IDX_W-1:0] idx,
                                      input logic [WEIGHT_W-1:0] w);
    node_t n;
    n.weight = NODE_W'(w);
    n.order  = ORDER_W'(idx);
    n.active = 1'b1;
    n.mask   = N_CHAR'(1) << idx;
    return n;
  endfunction

endpackage

// File: rtl/ht_min2_select.sv
// Combinational tournament tree returning the two active slots with the
// smallest {weight, order} keys; the second pass re-runs with the winner masked.
module ht_min2_select
  import ht_pkg::*;
(
  input  logic [N_CHAR*KEY_W-1:0] keys,
  input  logic [N_CHAR-1:0]       active,
  output logic [IDX_W-1:0]        first_idx,
  output logic [IDX_W-1:0]        second_idx
);

  function automatic logic a_wins(input logic va, input logic [KEY_W-1:0] ka,
                                  input logic vb, input logic [KEY_W-1:0] kb);
    return va && (!vb || (ka < kb));
  endfunction

  function automatic logic [IDX_W-1:0] tree_min(input logic [N_CHAR*KEY_W-1:0] k,
                                                input logic [N_CHAR-1:0] v);
    logic [3:0][KEY_W-1:0] k1;
    logic [3:0][IDX_W-1:0] i1;
    logic [3:0]            v1;
    logic [1:0][KEY_W-1:0] k2;
    logic [1:0][IDX_W-1:0] i2;
    logic [1:0]            v2;
    for (int j = 0; j < 4; j++) begin
      if (a_wins(v[2*j], k[2*j*KEY_W +: KEY_W], v[2*j+1], k[(2*j+1)*KEY_W +: KEY_W])) begin
        k1[j] = k[2*j*KEY_W +: KEY_W];
        i1[j] = IDX_W'(2*j);
        v1[j] = v[2*j];
      end else begin
        k1[j] = k[(2*j+1)*KEY_W +: KEY_W];
        i1[j] = IDX_W'(2*j+1);
        v1[j] = v[2*j+1];
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (a_wins(v1[2*j], k1[2*j], v1[2*j+1], k1[2*j+1])) begin
        k2[j] = k1[2*j];
        i2[j] = i1[2*j];
        v2[j] = v1[2*j];
      end else begin
        k2[j] = k1[2*j+1];
        i2[j] = i1[2*j+1];
        v2[j] = v1[2*j+1];
      end
    end
    return a_wins(v2[0], k2[0], v2[1], k2[1]) ? i2[0] : i2[1];
  endfunction

  assign first_idx  = tree_min(keys, active);
  assign second_idx = tree_min(keys, active & ~(N_CHAR'(1) << first_idx));

endmodule

// File: rtl/huffman_code_builder.sv
// Loads 8 weights, performs 7 min-2 merges (one per cycle) growing each leaf's
// code from the leaf side upward, then streams len/code per character.
module huffman_code_builder
  import ht_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [WEIGHT_W-1:0] in_weight,
  output logic                busy,
  output logic                out_valid,
  output logic [3:0]          out_char,
  output logic [2:0]          out_len,
  output logic [CODE_W-1:0]   out_code
);

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  node_t             node   [N_CHAR];
  logic [2:0]        len_q  [N_CHAR];
  logic [CODE_W-1:0] code_q [N_CHAR];

  logic [N_CHAR*KEY_W-1:0] keys;
  logic [N_CHAR-1:0]       act;
  logic [IDX_W-1:0]        first_idx;
  logic [IDX_W-1:0]        second_idx;
  node_t                   first_n;
  node_t                   second_n;

  always_comb begin
    for (int i = 0; i < N_CHAR; i++) begin
      keys[i*KEY_W +: KEY_W] = {node[i].weight, node[i].order};
      act[i]                 = node[i].active;
    end
  end

  ht_min2_select u_sel (
    .keys       (keys),
    .active     (act),
    .first_idx  (first_idx),
    .second_idx (second_idx)
  );

  assign first_n  = node[first_idx];
  assign second_n = node[second_idx];

  // NOTE: node/code arrays are small register files, so they are reset
  // explicitly; an abort must not leave stale masks for the next job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= '0;
      out_len   <= '0;
      out_code  <= '0;
      for (int i = 0; i < N_CHAR; i++) begin
        node[i]   <= '0;
        len_q[i]  <= '0;
        code_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge state.
      out_valid <= 1'b0;
      out_char  <= '0;
      out_len   <= '0;
      out_code  <= '0;
      unique case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (in_valid) begin
            busy  <= 1'b1;
            state <= S_LOAD;
            cnt   <= IDX_W'(1);
            for (int i = 0; i < N_CHAR; i++) begin
              node[i]   <= '0;
              len_q[i]  <= '0;
              code_q[i] <= '0;
            end
            node[0] <= make_leaf('0, in_weight);
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            node[cnt] <= make_leaf(cnt, in_weight);
            if (cnt == IDX_W'(N_CHAR - 1)) begin
              state <= S_MERGE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_MERGE: begin
          // Leaves under the second (larger) subtree take a 1 at their current depth.
          for (int i = 0; i < N_CHAR; i++) begin
            if (first_n.mask[i] || second_n.mask[i]) begin
              code_q[i][len_q[i]] <= second_n.mask[i];
              len_q[i]            <= len_q[i] + 1'b1;
            end
          end
          node[first_idx].weight  <= first_n.weight + second_n.weight;
          node[first_idx].order   <= ORDER_W'(N_CHAR) + ORDER_W'(cnt);
          node[first_idx].mask    <= first_n.mask | second_n.mask;
          node[second_idx].active <= 1'b0;
          if (cnt == IDX_W'(N_CHAR - 2)) begin
            state <= S_OUT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_OUT: begin
          out_valid <= 1'b1;
          out_char  <= 4'(cnt);
          out_len   <= len_q[cnt];
          out_code  <= code_q[cnt];
          if (cnt == IDX_W'(N_CHAR - 1)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_code_builder.sv
// Directed bench for huffman_code_builder: fixed weight sets with hand-derived
// code tables, latency, busy framing, ignored input, mid-job reset, back-to-back.
module tb_huffman_code_builder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_weight = '0;
  logic       busy;
  logic       out_valid;
  logic [3:0] out_char;
  logic [2:0] out_len;
  logic [6:0] out_code;

  int checks = 0;
  int failures = 0;

  huffman_code_builder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_weight (in_weight),
    .busy      (busy),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_len   (out_len),
    .out_code  (out_code)
  );

  always #5 clk = ~clk;

  // Drives beats 0..7; returns #1 after the edge that samples beat 7.
  task automatic drive_job(input logic [7:0][4:0] w);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_after_beat0 actual=%b required=1", busy);
        end
      end
      in_valid  = 1'b1;
      in_weight = w[k];
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_weight = '0;
  endtask

  task automatic check_stream(input string name, input logic [7:0][2:0] el,
                              input logic [7:0][6:0] ec, input bit noise,
                              input bit idle_after);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (noise && lat == 2) begin
        in_valid  = 1'b1;
        in_weight = 5'd0;
      end
      if (noise && lat == 4) begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL %s_latency actual=%0d required=8", name, lat);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_char !== 4'(c)) begin
        failures++;
        $display("FAIL %s_frame beat=%0d actual valid=%b busy=%b char=%0d required 1/1/%0d",
                 name, c, out_valid, busy, out_char, c);
      end
      checks++;
      if (out_len !== el[c] || out_code !== ec[c]) begin
        failures++;
        $display("FAIL %s_code char=%0d actual len=%0d code=%b required len=%0d code=%b",
                 name, c, out_len, out_code, el[c], ec[c]);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (out_valid !== 1'b0 || out_code !== 7'd0 || out_len !== 3'd0) begin
      failures++;
      $display("FAIL %s_after actual valid=%b len=%0d code=%b required 0/0/0",
               name, out_valid, out_len, out_code);
    end
    if (idle_after) begin
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy_idle actual=%b required=0", name, busy);
      end
    end
  endtask

  task automatic fill_binary(output logic [7:0][2:0] el, output logic [7:0][6:0] ec);
    for (int k = 0; k < 8; k++) begin
      el[k] = 3'd3;
      ec[k] = 7'(k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_char !== 4'd0 ||
        out_len !== 3'd0 || out_code !== 7'd0) begin
      failures++;
      $display("FAIL reset_state actual busy=%b valid=%b char=%0d len=%0d code=%b required all 0",
               busy, out_valid, out_char, out_len, out_code);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_all_ones();
    logic [7:0][4:0] w;
    logic [7:0][2:0] el;
    logic [7:0][6:0] ec;
    for (int k = 0; k < 8; k++) w[k] = 5'd1;
    fill_binary(el, ec);
    drive_job(w);
    check_stream("ones", el, ec, 1'b0, 1'b1);
  endtask

  task automatic test_all_zero();
    logic [7:0][4:0] w;
    logic [7:0][2:0] el;
    logic [7:0][6:0] ec;
    for (int k = 0; k < 8; k++) w[k] = 5'd0;
    fill_binary(el, ec);
    drive_job(w);
    check_stream("zeros", el, ec, 1'b0, 1'b1);
  endtask

  task automatic test_skewed();
    logic [7:0][4:0] w;
    logic [7:0][2:0] el;
    logic [7:0][6:0] ec;
    w  = {5'd31, 5'd31, 5'd16, 5'd8, 5'd4, 5'd2, 5'd1, 5'd1};
    el = {3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};
    ec = {7'b0000011, 7'b0000010, 7'b0000000, 7'b0000010,
          7'b0000110, 7'b0001110, 7'b0011111, 7'b0011110};
    drive_job(w);
    check_stream("skewed", el, ec, 1'b0, 1'b1);
  endtask

  task automatic test_max_ignore();
    logic [7:0][4:0] w;
    logic [7:0][2:0] el;
    logic [7:0][6:0] ec;
    for (int k = 0; k < 8; k++) w[k] = 5'd31;
    fill_binary(el, ec);
    drive_job(w);
    check_stream("max_noise", el, ec, 1'b1, 1'b1);
  endtask

  task automatic test_abort();
    logic [7:0][4:0] w;
    logic [7:0][2:0] el;
    logic [7:0][6:0] ec;
    bit seen = 1'b0;
    for (int k = 0; k < 8; k++) w[k] = 5'd1;
    fill_binary(el, ec);
    drive_job(w);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_immediate actual busy=%b valid=%b required 0/0", busy, out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_quiet actual activity=1 required=0");
    end
    drive_job(w);
    check_stream("after_abort", el, ec, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0][4:0] wa;
    logic [7:0][4:0] wb;
    logic [7:0][2:0] ela;
    logic [7:0][6:0] eca;
    logic [7:0][2:0] elb;
    logic [7:0][6:0] ecb;
    wa  = {5'd31, 5'd31, 5'd16, 5'd8, 5'd4, 5'd2, 5'd1, 5'd1};
    ela = {3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};
    eca = {7'b0000011, 7'b0000010, 7'b0000000, 7'b0000010,
           7'b0000110, 7'b0001110, 7'b0011111, 7'b0011110};
    for (int k = 0; k < 8; k++) wb[k] = 5'd1;
    fill_binary(elb, ecb);
    drive_job(wa);
    fork
      check_stream("b2b_first", ela, eca, 1'b0, 1'b0);
      begin
        repeat (14) @(posedge clk);
        drive_job(wb);
      end
    join
    check_stream("b2b_second", elb, ecb, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_all_zero();
    test_skewed();
    test_max_ignore();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
